// File: rtl/disp_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the 4-digit display scan controller:
//   state_t      - scan FSM state encoding (IDLE / SHOW / BLANK)
//   NUM_DIGITS   - number of multiplexed digits
//   SEL_W        - width of the digit index driven to decoder2to4
//   get_nibble() - pulls digit i out of the packed 16-bit digit bus
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Digit i lives in bus[4*i+3:4*i].
    function automatic logic [3:0] get_nibble(input logic [15:0]      bus,
                                              input logic [SEL_W-1:0] idx);
        return bus[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Slot counter for the display scan. Counts 0..CLK_DIV-1 and wraps; the
// clear input holds it at 0 (scan stopped or waiting to start).
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   i_clr         - synchronous clear to 0
//   o_cnt         - current position inside the slot
//   o_show_end    - last visible cycle of the slot (cnt == CLK_DIV-BLANK_CYC-1)
//   o_slot_end    - last cycle of the slot (cnt == CLK_DIV-1)
// ---------------------------------------------------------------------------
module scan_prescaler #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CW        = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_show_end,
    output logic          o_slot_end
);

    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_slot_end;

    assign w_slot_end = (r_cnt == SLOT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr || w_slot_end)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_cnt      = r_cnt;
    assign o_show_end = (r_cnt == SHOW_LAST);
    assign o_slot_end = w_slot_end;

endmodule

// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
// Time-multiplexed scan controller for a 4-digit display, feeding
// decoder2to4. Each slot shows one digit for CLK_DIV-BLANK_CYC cycles, then
// forces the digit off for BLANK_CYC cycles to suppress ghosting. Masked
// digits are still scanned (constant duty) but never enabled.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   run          - 1 = scanning, 0 = stopped with all outputs off
//   digit_data   - four nibbles, digit i = digit_data[4i+3:4i]
//   dp_in        - decimal point per digit
//   digit_mask   - per-digit enable
//   sel, sel_en  - digit index / enable to decoder2to4
//   digit_out    - nibble of the current digit
//   dp_out       - decimal point of the current digit
//   frame_tick   - 1-cycle pulse whenever the scan (re)starts at digit 0
// All outputs are registered.
// ---------------------------------------------------------------------------
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [15:0]      digit_data,
    input  logic [3:0]       dp_in,
    input  logic [3:0]       digit_mask,
    output logic [SEL_W-1:0] sel,
    output logic             sel_en,
    output logic [3:0]       digit_out,
    output logic             dp_out,
    output logic             frame_tick
);

    localparam int            CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - BLANK_CYC - 1);
    localparam bit            NO_BLANK  = (BLANK_CYC == 0);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic             r_sel_en;
    logic [3:0]       r_digit;
    logic             r_dp;
    logic             r_frame_tick;

    logic [CW-1:0]    w_cnt;
    logic             w_show_end;
    logic             w_slot_end;
    logic             w_clr;
    logic [SEL_W-1:0] w_next_sel;

    // Counter is held at 0 while idle so the first SHOW cycle is cnt=0.
    assign w_clr = !run || (r_state == IDLE);

    scan_prescaler #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .CW        (CW)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .o_cnt      (w_cnt),
        .o_show_end (w_show_end),
        .o_slot_end (w_slot_end)
    );

    // Digit to load on the next SHOW entry: 0 when starting from IDLE,
    // otherwise the following digit (wraps 3 -> 0 naturally in 2 bits).
    assign w_next_sel = (r_state == IDLE) ? '0 : r_sel + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_sel_en     <= 1'b0;
            r_digit      <= '0;
            r_dp         <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (!run) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_sel_en     <= 1'b0;
            r_digit      <= '0;
            r_dp         <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            case (r_state)
                IDLE, BLANK: begin
                    // IDLE starts immediately; BLANK waits for the slot end.
                    if (r_state == IDLE || w_slot_end) begin
                        r_state      <= SHOW;
                        r_sel        <= w_next_sel;
                        r_sel_en     <= digit_mask[w_next_sel];
                        r_digit      <= get_nibble(digit_data, w_next_sel);
                        r_dp         <= dp_in[w_next_sel];
                        r_frame_tick <= (w_next_sel == '0);
                    end
                end
                SHOW: begin
                    if (NO_BLANK && w_slot_end) begin
                        // No gap configured: step straight to the next digit.
                        r_sel        <= w_next_sel;
                        r_sel_en     <= digit_mask[w_next_sel];
                        r_digit      <= get_nibble(digit_data, w_next_sel);
                        r_dp         <= dp_in[w_next_sel];
                        r_frame_tick <= (w_next_sel == '0);
                    end else if (w_show_end) begin
                        // Digit index and data are held through the gap.
                        r_state  <= BLANK;
                        r_sel_en <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sel        = r_sel;
    assign sel_en     = r_sel_en;
    assign digit_out  = r_digit;
    assign dp_out     = r_dp;
    assign frame_tick = r_frame_tick;

    // Blanking must only ever occupy the tail of the slot, and the digit
    // enable must be off whenever the digit is not being shown.
    a_blank_tail: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == BLANK) |-> (w_cnt > SHOW_LAST));
    a_en_only_show: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state != SHOW) |-> !r_sel_en);

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, run0;
    logic [15:0] digit_data;
    logic [3:0]  dp_in, digit_mask;

    logic [1:0]  sel, sel0;
    logic        sel_en, sel_en0;
    logic [3:0]  digit_out, digit_out0;
    logic        dp_out, dp_out0;
    logic        frame_tick, frame_tick0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // Main DUT: 8-cycle slots, 2-cycle gap.
    disp_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .digit_data(digit_data), .dp_in(dp_in), .digit_mask(digit_mask),
        .sel(sel), .sel_en(sel_en), .digit_out(digit_out),
        .dp_out(dp_out), .frame_tick(frame_tick));

    // Second build with no blanking gap.
    disp_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0),
        .digit_data(digit_data), .dp_in(dp_in), .digit_mask(digit_mask),
        .sel(sel0), .sel_en(sel_en0), .digit_out(digit_out0),
        .dp_out(dp_out0), .frame_tick(frame_tick0));

    // Packed view: {sel, sel_en, digit_out, dp_out, frame_tick}
    logic [8:0] obs, obs0;
    assign obs  = {sel,  sel_en,  digit_out,  dp_out,  frame_tick};
    assign obs0 = {sel0, sel_en0, digit_out0, dp_out0, frame_tick0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packed outputs for scan cycle c (c=0 is the start edge),
    // 8-cycle slots, 'show' visible cycles per slot.
    function automatic logic [8:0] exp_scan(input int c, input int show,
                                            input logic [3:0] m, input logic [15:0] d,
                                            input logic [3:0] p);
        int slot, pos;
        logic [3:0] nib;
        slot = (c / 8) % 4;
        pos  = c % 8;
        nib  = d[4*slot +: 4];
        return {slot[1:0], (m[slot] && pos < show), nib, p[slot], (c % 32 == 0)};
    endfunction

    initial begin
        logic [15:0] d;
        rst_n = 1'b0; run = 1'b0; run0 = 1'b0;
        digit_data = 16'h4321; dp_in = 4'b0100; digit_mask = 4'b1111;

        // Reset / idle
        #1 chk("reset", {23'd0, obs}, 32'd0);
        #11 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle", {23'd0, obs}, 32'd0);
            chk("idle0", {23'd0, obs0}, 32'd0);
        end

        // Basic scan, all digits on
        run = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk($sformatf("scan c%0d", c), {23'd0, obs},
                {23'd0, exp_scan(c, 6, 4'b1111, 16'h4321, 4'b0100)});
        end
        run = 1'b0;
        tick();
        chk("stop1", {23'd0, obs}, 32'd0);

        // Masking: only digits 1 and 3 lit
        digit_mask = 4'b1010; run = 1'b1;
        for (int c = 0; c < 32; c++) begin
            tick();
            chk($sformatf("mask c%0d", c), {23'd0, obs},
                {23'd0, exp_scan(c, 6, 4'b1010, 16'h4321, 4'b0100)});
        end
        run = 1'b0;
        tick();
        chk("stop2", {23'd0, obs}, 32'd0);

        // Mid-slot data change at cnt=3 of slot 1; visible from slot 2 entry
        digit_mask = 4'b1111; run = 1'b1;
        for (int c = 0; c < 48; c++) begin
            tick();
            d = (c < 16) ? 16'h4321 : 16'h8765;
            chk($sformatf("chg c%0d", c), {23'd0, obs},
                {23'd0, exp_scan(c, 6, 4'b1111, d, 4'b0100)});
            if (c == 11) digit_data = 16'h8765;
        end
        run = 1'b0;
        tick();
        chk("stop3", {23'd0, obs}, 32'd0);

        // run dropped at cnt=4 of slot 2, then restarted
        digit_data = 16'h4321; run = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            tick();
            chk($sformatf("run c%0d", c), {23'd0, obs},
                {23'd0, exp_scan(c, 6, 4'b1111, 16'h4321, 4'b0100)});
        end
        run = 1'b0;
        tick();
        chk("run_off", {23'd0, obs}, 32'd0);
        run = 1'b1;
        tick();
        chk("restart", {23'd0, obs}, {23'd0, 9'b00_1_0001_0_1});

        // Async reset in the BLANK of slot 3 (restart counted from the edge above)
        for (int c = 1; c <= 30; c++) begin
            tick();
            chk($sformatf("pre_rst c%0d", c), {23'd0, obs},
                {23'd0, exp_scan(c, 6, 4'b1111, 16'h4321, 4'b0100)});
        end
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {23'd0, obs}, 32'd0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("post_rst c%0d", c), {23'd0, obs},
                {23'd0, exp_scan(c, 6, 4'b1111, 16'h4321, 4'b0100)});
        end

        // No-gap build: enable stays high, sel steps every 8 cycles
        run0 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk($sformatf("noblank c%0d", c), {23'd0, obs0},
                {23'd0, exp_scan(c, 8, 4'b1111, 16'h4321, 4'b0100)});
        end
        run0 = 1'b0;
        tick();
        chk("stop0", {23'd0, obs0}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
